// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared size encodings, FSM state type and lane helpers for the
//            mem_stage_ws memory pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t WAIT = 1'b1;

    // Size 2'b11 falls through to word handling in every helper.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return zext ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: return zext ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_be.sv
// ============================================================================
// Module   : data_ram_be
// Brief    : DEPTH x 32 data RAM, byte-enable synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_be #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    // One array per lane keeps each storage element single-driven.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && be[i]) begin
                r_mem[addr] <= wdata[8*i +: 8];
            end
        end

        assign rdata[8*i +: 8] = r_mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_ws.sv
// ============================================================================
// Module   : mem_stage_ws
// Brief    : Pipeline MEM stage with byte/half/word access, wait states and
//            upstream stall. Optional macro MEM_MISALIGN_TRAP_EN adds a
//            misaligned-access trap flag (wb_misalign).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ws
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd_in,
    input  logic              reg_write_in,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              wb_misalign,
`endif
    output logic [31:0]       wb_data
);

    localparam int         c_idx_w       = $clog2(DEPTH);
    localparam logic [3:0] c_wait_states = 4'(WAIT_STATES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_stall;
    logic        w_access;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [31:0] w_load_data;
    logic [31:0] w_addr32;

    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic        r_wb_reg_write;
    logic [31:0] r_wb_data;

    assign w_mem_op = mem_read | mem_write;

    if (ADDR_W >= 32) begin : g_addr_trunc
        assign w_addr32 = addr[31:0];
    end else begin : g_addr_ext
        assign w_addr32 = {{(32-ADDR_W){1'b0}}, addr};
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = in_valid && w_mem_op && misaligned(mem_size, addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && w_mem_op && (c_wait_states != 4'd0)) begin
                    w_stall     = 1'b1;
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = WAIT;
                end else begin
                    w_access = 1'b1;
                end
            end
            WAIT: begin
                // r_cnt never exceeds c_wait_states here, so != is the same as <.
                w_stall = (r_cnt != c_wait_states);
                if (r_cnt == c_wait_states) begin
                    w_access    = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        if (rst) begin
            w_stall = 1'b0;
        end
    end

    assign w_be    = byte_en(mem_size, addr[1:0]);
    assign w_wdata = store_data(mem_size, wdata);
    assign w_we    = in_valid && mem_write && w_access && !w_misalign && !rst;

    data_ram_be #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .be    (w_be),
        .addr  (addr[2 +: c_idx_w]),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    assign w_load_data = load_extract(w_rdata, mem_size, addr[1:0], load_unsigned);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= 4'd0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!in_valid || w_stall) begin
                r_wb_valid     <= 1'b0;
                r_wb_reg_write <= 1'b0;
            end else if (w_misalign) begin
                r_wb_valid     <= 1'b1;
                r_wb_rd        <= rd_in;
                r_wb_reg_write <= 1'b0;
                r_wb_data      <= 32'd0;
            end else begin
                r_wb_valid     <= 1'b1;
                r_wb_rd        <= rd_in;
                r_wb_reg_write <= reg_write_in;
                r_wb_data      <= mem_read ? w_load_data : w_addr32;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_wb_misalign;

    always_ff @(posedge clk) begin
        r_wb_misalign <= !rst && in_valid && !w_stall && w_misalign;
    end

    assign wb_misalign = r_wb_misalign;
`endif

    assign stall        = w_stall;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_data      = r_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ws.sv
// ============================================================================
// Module   : tb_mem_stage_ws
// Brief    : Directed self-checking bench for mem_stage_ws with zero and three
//            wait states; covers MEM_MISALIGN_TRAP_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ws;

    localparam logic [1:0] c_b = 2'b00;
    localparam logic [1:0] c_h = 2'b01;
    localparam logic [1:0] c_w = 2'b10;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst3;
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_in;
    logic        reg_write_in;

    logic        stall0, wb_valid0, wb_rw0;
    logic [4:0]  wb_rd0;
    logic [31:0] wb_data0;
    logic        stall3, wb_valid3, wb_rw3;
    logic [4:0]  wb_rd3;
    logic [31:0] wb_data3;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misal0, misal3;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ws #(.ADDR_W(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .clk           (clk),
        .rst           (rst0),
        .in_valid      (in_valid),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .stall         (stall0),
        .wb_valid      (wb_valid0),
        .wb_rd         (wb_rd0),
        .wb_reg_write  (wb_rw0),
`ifdef MEM_MISALIGN_TRAP_EN
        .wb_misalign   (misal0),
`endif
        .wb_data       (wb_data0)
    );

    mem_stage_ws #(.ADDR_W(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .clk           (clk),
        .rst           (rst3),
        .in_valid      (in_valid),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .stall         (stall3),
        .wb_valid      (wb_valid3),
        .wb_rd         (wb_rd3),
        .wb_reg_write  (wb_rw3),
`ifdef MEM_MISALIGN_TRAP_EN
        .wb_misalign   (misal3),
`endif
        .wb_data       (wb_data3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd_, input logic wr_, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input logic rw);
        in_valid      = v;
        mem_read      = rd_;
        mem_write     = wr_;
        mem_size      = sz;
        load_unsigned = uns;
        addr          = a;
        wdata         = d;
        rd_in         = r;
        reg_write_in  = rw;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 0, 0, c_w, 0, 32'h0, 32'h0, 5'd0, 0);
        tick;
        tick;
        chk("rst_valid0", wb_valid0, 0);
        chk("rst_data0", wb_data0, 0);
        chk("rst_rd0", wb_rd0, 0);
        chk("rst_rw0", wb_rw0, 0);
        chk("rst_stall0", stall0, 0);
        chk("rst_valid3", wb_valid3, 0);
        chk("rst_stall3", stall3, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("rst_misal0", misal0, 0);
`endif

        // ---------------- zero wait states ----------------
        rst0 = 1'b0;
        drive(1, 0, 1, c_w, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0);
        chk("sw_stall", stall0, 0);
        tick;
        chk("sw_valid", wb_valid0, 1);
        chk("sw_rw", wb_rw0, 0);

        drive(1, 1, 0, c_w, 0, 32'h10, 32'h0, 5'd5, 1);
        chk("lw_stall", stall0, 0);
        tick;
        chk("lw_data", wb_data0, 32'hDEADBEEF);
        chk("lw_rd", wb_rd0, 5);
        chk("lw_rw", wb_rw0, 1);

        drive(1, 0, 1, c_b, 0, 32'h13, 32'h12345680, 5'd0, 0);
        tick;
        drive(1, 1, 0, c_b, 0, 32'h13, 32'h0, 5'd6, 1);
        tick;
        chk("lb_neg", wb_data0, 32'hFFFFFF80);
        drive(1, 1, 0, c_b, 1, 32'h13, 32'h0, 5'd6, 1);
        tick;
        chk("lbu", wb_data0, 32'h00000080);
        drive(1, 1, 0, c_h, 0, 32'h12, 32'h0, 5'd6, 1);
        tick;
        chk("lh_upper", wb_data0, 32'hFFFF80AD);
        drive(1, 1, 0, c_h, 1, 32'h10, 32'h0, 5'd6, 1);
        tick;
        chk("lhu_lower", wb_data0, 32'h0000BEEF);
        drive(1, 1, 0, c_b, 0, 32'h11, 32'h0, 5'd6, 1);
        tick;
        chk("lb_lane1", wb_data0, 32'hFFFFFFBE);

        // 0x1000 is word 1024, which aliases word 0 in a 1024-word RAM
        drive(1, 0, 1, c_w, 0, 32'h1000, 32'hCAFEF00D, 5'd0, 0);
        tick;
        drive(1, 1, 0, c_w, 0, 32'h0, 32'h0, 5'd8, 1);
        tick;
        chk("wrap_lw", wb_data0, 32'hCAFEF00D);

        drive(1, 0, 1, c_h, 0, 32'h2, 32'hAAAA7F01, 5'd0, 0);
        tick;
        drive(1, 1, 0, c_w, 0, 32'h0, 32'h0, 5'd8, 1);
        tick;
        chk("sh_lw", wb_data0, 32'h7F01F00D);

        drive(1, 1, 0, c_h, 0, 32'h3, 32'h0, 5'd9, 1);
        tick;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lh_mis_data", wb_data0, 0);
        chk("lh_mis_flag", misal0, 1);
        chk("lh_mis_rw", wb_rw0, 0);
        chk("lh_mis_valid", wb_valid0, 1);
`else
        chk("lh_odd", wb_data0, 32'h00007F01);
`endif

        drive(1, 0, 0, c_w, 0, 32'h1234, 32'h0, 5'd7, 1);
        chk("alu_stall", stall0, 0);
        tick;
        chk("alu_data", wb_data0, 32'h1234);
        chk("alu_rd", wb_rd0, 7);
        chk("alu_rw", wb_rw0, 1);
        chk("alu_valid", wb_valid0, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("alu_misal", misal0, 0);
`endif

        drive(0, 0, 0, c_w, 0, 32'h9999, 32'h0, 5'd3, 1);
        tick;
        chk("nop_valid", wb_valid0, 0);
        chk("nop_rw", wb_rw0, 0);
        chk("nop_data_hold", wb_data0, 32'h1234);
        chk("nop_rd_hold", wb_rd0, 7);

`ifdef MEM_MISALIGN_TRAP_EN
        drive(1, 0, 1, c_w, 0, 32'h20, 32'h0BADF00D, 5'd0, 0);
        tick;
        drive(1, 0, 1, c_w, 0, 32'h22, 32'hFFFFFFFF, 5'd4, 1);
        tick;
        chk("sw_mis_flag", misal0, 1);
        chk("sw_mis_rw", wb_rw0, 0);
        chk("sw_mis_valid", wb_valid0, 1);
        chk("sw_mis_data", wb_data0, 0);
        drive(1, 1, 0, c_w, 0, 32'h20, 32'h0, 5'd3, 1);
        tick;
        chk("lw_after_mis", wb_data0, 32'h0BADF00D);
        chk("lw_mis_flag", misal0, 0);
`endif

        // ---------------- three wait states ----------------
        rst0 = 1'b1;
        rst3 = 1'b0;
        drive(0, 0, 0, c_w, 0, 32'h0, 32'h0, 5'd0, 0);
        tick;
        chk("ws3_idle_stall", stall3, 0);

        drive(1, 0, 1, c_w, 0, 32'h40, 32'h11223344, 5'd0, 0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("st_stall%0d", c), stall3, (c < 3) ? 1 : 0);
            tick;
            if (c < 3) chk($sformatf("st_bubble%0d", c), wb_valid3, 0);
        end
        chk("st_valid", wb_valid3, 1);

        drive(1, 1, 0, c_w, 0, 32'h40, 32'h0, 5'd9, 1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ld_stall%0d", c), stall3, (c < 3) ? 1 : 0);
            tick;
            if (c < 3) chk($sformatf("ld_bubble%0d", c), wb_valid3, 0);
        end
        chk("ld_valid", wb_valid3, 1);
        chk("ld_data", wb_data3, 32'h11223344);
        chk("ld_rd", wb_rd3, 9);

        drive(1, 0, 0, c_w, 0, 32'h55, 32'h0, 5'd2, 1);
        chk("ws3_alu_stall", stall3, 0);
        tick;
        chk("ws3_alu_data", wb_data3, 32'h55);
        chk("ws3_alu_valid", wb_valid3, 1);

        // reset lands in the second stalled cycle of a store
        drive(1, 0, 1, c_w, 0, 32'h40, 32'h55667788, 5'd0, 0);
        chk("rw_stall_a", stall3, 1);
        tick;
        chk("rw_stall_b", stall3, 1);
        rst3 = 1'b1;
        tick;
        chk("rw_valid", wb_valid3, 0);
        chk("rw_rw", wb_rw3, 0);
        chk("rw_data", wb_data3, 0);
        chk("rw_rd", wb_rd3, 0);
        chk("rw_stall", stall3, 0);
        rst3 = 1'b0;
        drive(0, 0, 0, c_w, 0, 32'h0, 32'h0, 5'd0, 0);
        chk("rw_idle_stall", stall3, 0);
        tick;

        drive(1, 1, 0, c_w, 0, 32'h40, 32'h0, 5'd1, 1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rl_stall%0d", c), stall3, (c < 3) ? 1 : 0);
            tick;
        end
        chk("rl_data_unchanged", wb_data3, 32'h11223344);
        chk("rl_valid", wb_valid3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
